// File: rtl/switch_debouncer_pkg.sv
// Shared LED-block definitions used by the switch debouncer.
//   SW_WIDTH                : default number of DIP-switch bits
//   DEBOUNCE_CYCLES_DEFAULT : default stability window (10 ms at 48 MHz)
//   db_state_t              : per-bit debounce FSM state
package led_pkg;
   localparam int SW_WIDTH                = 4;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 480000;

   typedef enum logic {
      DB_STABLE  = 1'b0,
      DB_PENDING = 1'b1
   } db_state_t;
endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: two-flop synchronizer, stability FSM and counter.
// Ports:
//   int_osc  : clock (rising edge)
//   reset_n  : asynchronous active-low reset
//   s_raw    : raw asynchronous switch pin
//   s_db     : debounced level (registered)
//   commit   : high in the cycle before the edge on which s_db flips
module debounce_bit
   import led_pkg::*;
#(
   parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic int_osc,
   input  logic reset_n,
   input  logic s_raw,
   output logic s_db,
   output logic commit
);
   localparam int              CW      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);

   db_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          s_db_q, s_db_d;
   logic          differ, at_max;

   assign sync1_d = s_raw;
   assign sync2_d = sync1_q;

   // The FSM judges the level sync2 takes on this same edge, so the edge
   // where sync2 picks up a new level already counts as stable cycle 1.
   assign differ = (sync2_d != s_db_q);
   assign at_max = (cnt_q == CNT_MAX);

   always_ff @(posedge int_osc or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= DB_STABLE;
         cnt_q   <= '0;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         s_db_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         s_db_q  <= s_db_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DB_STABLE:  if (differ) state_d = DB_PENDING;
         DB_PENDING: if (!differ || at_max) state_d = DB_STABLE;
         default:    state_d = DB_STABLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      s_db_d = s_db_q;
      commit = 1'b0;
      case (state_q)
         DB_STABLE: cnt_d = differ ? CW'(1) : '0;
         DB_PENDING: begin
            if (!differ) begin
               cnt_d = '0;
            end else if (at_max) begin
               cnt_d  = '0;
               commit = 1'b1;
               // A commit needs at least one earlier pending edge, so sync2_q
               // already holds the new level here.
               s_db_d = sync2_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: cnt_d = '0;
      endcase
   end

   assign s_db = s_db_q;
endmodule

// File: rtl/switch_debouncer.sv
// Debounces the DIP-switch bus feeding the LED block.
// Ports:
//   int_osc  : clock (rising edge)
//   reset_n  : asynchronous active-low reset
//   s_raw    : raw switch pins
//   s_db     : debounced switch levels (to LED block input s)
//   changed  : one-cycle strobe when any s_db bit commits
//   s_rise   : per-bit one-cycle 0->1 commit pulse
//   s_fall   : per-bit one-cycle 1->0 commit pulse
// Build option: SWITCH_DEBOUNCER_EDGE_PULSE_EN builds s_rise/s_fall; when
// undefined both outputs are tied to 0.
module switch_debouncer
   import led_pkg::*;
#(
   parameter int WIDTH         = SW_WIDTH,
   parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             int_osc,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] s_raw,
   output logic [WIDTH-1:0] s_db,
   output logic             changed,
   output logic [WIDTH-1:0] s_rise,
   output logic [WIDTH-1:0] s_fall
);
   logic [WIDTH-1:0] commit;
   logic             changed_q, changed_d;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      debounce_bit #(
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_bit (
         .int_osc (int_osc),
         .reset_n (reset_n),
         .s_raw   (s_raw[g]),
         .s_db    (s_db[g]),
         .commit  (commit[g])
      );
   end

   assign changed_d = |commit;

   always_ff @(posedge int_osc or negedge reset_n) begin
      if (!reset_n) changed_q <= 1'b0;
      else          changed_q <= changed_d;
   end

   assign changed = changed_q;

`ifdef SWITCH_DEBOUNCER_EDGE_PULSE_EN
   logic [WIDTH-1:0] s_rise_q, s_rise_d;
   logic [WIDTH-1:0] s_fall_q, s_fall_d;

   // s_db still shows the old level while commit is high.
   assign s_rise_d = commit & ~s_db;
   assign s_fall_d = commit & s_db;

   always_ff @(posedge int_osc or negedge reset_n) begin
      if (!reset_n) begin
         s_rise_q <= '0;
         s_fall_q <= '0;
      end else begin
         s_rise_q <= s_rise_d;
         s_fall_q <= s_fall_d;
      end
   end

   assign s_rise = s_rise_q;
   assign s_fall = s_fall_q;
`else
   assign s_rise = '0;
   assign s_fall = '0;
`endif
endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;
   localparam int W = 4;
   localparam int S = 4;

   logic         int_osc = 1'b0;
   logic         reset_n;
   logic [W-1:0] s_raw;
   logic [W-1:0] s_db, s_rise, s_fall;
   logic         changed;

   int vectors = 0;
   int errors  = 0;

   always #5 int_osc = ~int_osc;

   switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
      .int_osc (int_osc),
      .reset_n (reset_n),
      .s_raw   (s_raw),
      .s_db    (s_db),
      .changed (changed),
      .s_rise  (s_rise),
      .s_fall  (s_fall)
   );

   // Model: the synchronized level seen after edge k is s_raw as sampled at
   // edge k-1. A bit commits at edge k when that level and the S levels
   // before it all differ from the current debounced value.
   logic [W-1:0] m_prev, m_db, m_rise, m_fall;
   logic         m_chg;
   logic [W-1:0] m_hist [S];

   function automatic logic [W-1:0] f_commit(input logic [W-1:0] y,
                                             input logic [W-1:0] h [S],
                                             input logic [W-1:0] db);
      logic [W-1:0] c;
      c = y ^ db;
      for (int j = 0; j < S; j++) c = c & (h[j] ^ db);
      return c;
   endfunction

   always @(posedge int_osc or negedge reset_n) begin
      if (!reset_n) begin
         m_prev <= '0;
         m_db   <= '0;
         m_rise <= '0;
         m_fall <= '0;
         m_chg  <= 1'b0;
         for (int j = 0; j < S; j++) m_hist[j] <= '0;
      end else begin
         m_prev    <= s_raw;
         m_hist[0] <= m_prev;
         for (int j = 1; j < S; j++) m_hist[j] <= m_hist[j-1];
         m_db   <= m_db ^ f_commit(m_prev, m_hist, m_db);
         m_chg  <= |f_commit(m_prev, m_hist, m_db);
         m_rise <= f_commit(m_prev, m_hist, m_db) & ~m_db;
         m_fall <= f_commit(m_prev, m_hist, m_db) & m_db;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] edge_exp(input logic [W-1:0] v);
`ifdef SWITCH_DEBOUNCER_EDGE_PULSE_EN
      return v;
`else
      return '0;
`endif
   endfunction

   always @(negedge int_osc) begin
      chk("model_s_db",    32'(s_db),    32'(m_db));
      chk("model_changed", 32'(changed), 32'(m_chg));
      chk("model_s_rise",  32'(s_rise),  32'(edge_exp(m_rise)));
      chk("model_s_fall",  32'(s_fall),  32'(edge_exp(m_fall)));
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge int_osc);
         @(negedge int_osc);
      end
   endtask

   typedef struct { logic [W-1:0] v; int hold; } seg_t;
   seg_t segs [8];

   initial begin
      reset_n = 1'b0;
      s_raw   = '0;
      tick(3);
      reset_n = 1'b1;
      tick(8);
      chk("idle_s_db", 32'(s_db), 32'h0);

      // Clean 0->1 on bit 0; s_db flips at E0+5.
      s_raw = 4'b0001;
      tick(5);
      chk("clean_e4_s_db", 32'(s_db), 32'h0);
      tick(1);
      chk("clean_e5_s_db",    32'(s_db),    32'h1);
      chk("clean_e5_changed", 32'(changed), 32'h1);
      chk("clean_e5_s_rise",  32'(s_rise),  32'(edge_exp(4'b0001)));
      chk("clean_e5_s_fall",  32'(s_fall),  32'h0);
      tick(1);
      chk("clean_e6_changed", 32'(changed), 32'h0);
      chk("clean_e6_s_rise",  32'(s_rise),  32'h0);
      tick(6);

      // Bounce on bit 1: 1,0,1 then hold.
      s_raw = 4'b0011; tick(1);
      s_raw = 4'b0001; tick(1);
      s_raw = 4'b0011;
      tick(5);
      chk("bounce_e4_s_db", 32'(s_db), 32'h1);
      tick(1);
      chk("bounce_e5_s_db",    32'(s_db),    32'h3);
      chk("bounce_e5_changed", 32'(changed), 32'h1);
      tick(1);
      chk("bounce_e6_changed", 32'(changed), 32'h0);
      tick(6);

      // Three-cycle glitch on bit 2 never commits.
      s_raw = 4'b0111; tick(3);
      s_raw = 4'b0011; tick(12);
      chk("glitch_s_db", 32'(s_db), 32'h3);

      // Return to zero, then two bits rise together.
      s_raw = 4'b0000; tick(12);
      chk("zero_s_db", 32'(s_db), 32'h0);
      s_raw = 4'b1100;
      tick(6);
      chk("simul_s_db",    32'(s_db),    32'hC);
      chk("simul_changed", 32'(changed), 32'h1);
      chk("simul_s_rise",  32'(s_rise),  32'(edge_exp(4'b1100)));
      tick(1);
      chk("simul_next_changed", 32'(changed), 32'h0);
      tick(4);

      // Reset while bits 0/1 are pending, switches held high.
      s_raw = 4'b1111;
      tick(3);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_s_db",    32'(s_db),    32'h0);
      chk("rst_changed", 32'(changed), 32'h0);
      chk("rst_s_rise",  32'(s_rise),  32'h0);
      chk("rst_s_fall",  32'(s_fall),  32'h0);
      @(negedge int_osc);
      tick(2);
      reset_n = 1'b1;
      tick(5);
      chk("rel_e5_s_db", 32'(s_db), 32'h0);
      tick(1);
      chk("rel_e6_s_db",    32'(s_db),    32'hF);
      chk("rel_e6_changed", 32'(changed), 32'h1);
      chk("rel_e6_s_rise",  32'(s_rise),  32'(edge_exp(4'b1111)));
      tick(1);
      chk("rel_e7_changed", 32'(changed), 32'h0);

      // Mixed holds around the stability window, checked by the model.
      segs[0] = '{4'b0000, 7};
      segs[1] = '{4'b1010, 4};
      segs[2] = '{4'b0101, 9};
      segs[3] = '{4'b1010, 5};
      segs[4] = '{4'b0101, 6};
      segs[5] = '{4'b0110, 3};
      segs[6] = '{4'b1001, 10};
      segs[7] = '{4'b0000, 12};
      for (int i = 0; i < 8; i++) begin
         s_raw = segs[i].v;
         tick(segs[i].hold);
      end
      chk("final_s_db", 32'(s_db), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Conditions the raw DIP-switch inputs before they reach the LED logic block. Each bit passes through a two-flop synchronizer and a per-bit stability counter, so the debounced bus changes only after the input has held a new level for a programmable number of clock cycles. It also emits a one-cycle "any bit changed" strobe, plus optional per-bit rise and fall pulses. Its `s_db` output drives the `s` input of the LED block directly.

## Interface
- `WIDTH`, default 4: number of switch bits; must be ≥ 1.
- `STABLE_CYCLES`, default 480000: consecutive stable synchronized cycles required to commit a change (10 ms at 48 MHz); must be ≥ 1.

- `int_osc`, input, 1: the single clock, from the internal high-speed oscillator. All flops are clocked on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `s_raw`, input, WIDTH: raw, asynchronous switch pins.
- `s_db`, output, WIDTH: debounced, registered switch levels.
- `changed`, output, 1: one-cycle strobe, high when any `s_db` bit commits a new value.
- `s_rise`, output, WIDTH: one-cycle per-bit 0→1 commit pulse. Driven only when the macro in Configuration is defined.
- `s_fall`, output, WIDTH: one-cycle per-bit 1→0 commit pulse. Driven only when the macro in Configuration is defined.

## Operation
- **Synchronizer:** per bit, `sync1` ← `s_raw`, then `sync2` ← `sync1`. Only `sync2` is used downstream.
- **Per-bit FSM** (type `db_state_t`):
  - `DB_STABLE`: the counter is held at 0.
    - If `sync2` ≠ `s_db`, go to `DB_PENDING` and set the counter to 1.
  - `DB_PENDING`: checked in this order each cycle.
    - If `sync2` == `s_db`, the input bounced back: go to `DB_STABLE` and clear the counter. No commit and no strobe.
    - Else, if counter == `STABLE_CYCLES`: `s_db` ← `sync2`, go to `DB_STABLE`, clear the counter, and pulse this bit's commit.
    - Else, increment the counter.
- **Counter:** width is `$clog2(STABLE_CYCLES+1)`. It never exceeds `STABLE_CYCLES`, so it never wraps.
- **`changed`:** registered OR of all per-bit commits. When several bits commit on the same edge, `changed` produces a single one-cycle pulse.
- **`s_rise` / `s_fall`:** a bit's `s_rise` pulses when it commits a 1; its `s_fall` pulses when it commits a 0.
- **Bits are independent.** A bounce on one bit never resets another bit's counter.
- **Reset values** (asynchronous, when `reset_n` = 0): `sync1`, `sync2`, `s_db`, `changed`, `s_rise` and `s_fall` are all 0; every FSM is in `DB_STABLE`; every counter is 0.
- **Reset asserted mid-PENDING:** the pending change is discarded immediately.
- **Switches already high at reset release:** they go through the normal debounce and produce `changed` and `s_rise` pulses once committed.

## Timing
- Let E0 be the first edge at which `sync1` captures the new level.
  - `sync2` takes the new level at E0+1.
  - `s_db` takes the new level at E0+1+`STABLE_CYCLES`, provided `sync2` holds the new level throughout.
- `changed`, `s_rise` and `s_fall` go high on the same edge as the `s_db` update and return low on the next edge.
- A bounce resets the count. After the bounce, `STABLE_CYCLES` full cycles of the new level are needed again, measured from the edge where `sync2` reasserts it.
- A glitch visible for fewer than `STABLE_CYCLES` synchronized cycles never reaches `s_db`.
- Throughput: a bit can commit again at the earliest `STABLE_CYCLES`+1 cycles after its previous commit.

## Configuration
- Macro: `SWITCH_DEBOUNCER_EDGE_PULSE_EN`.
- **Defined:** the `s_rise` and `s_fall` registers and logic are built as described in Operation.
- **Undefined:**
  - The ports remain in the module.
  - `s_rise` and `s_fall` are tied to constant 0, and no edge registers are synthesized.
  - `s_db` and `changed` behave identically in both builds.

## Structure
- **Shared package `led_pkg`:**
  - `SW_WIDTH` = 4.
  - `DEBOUNCE_CYCLES_DEFAULT` = 480000.
  - `typedef enum logic {DB_STABLE, DB_PENDING} db_state_t`.
- **Sub-module `debounce_bit`:** one bit's synchronizer, FSM, counter and commit pulse, parameterized by `STABLE_CYCLES`.
- **Top level:** instantiates `WIDTH` copies of `debounce_bit` with a generate loop, ORs the commits into `changed`, and builds the edge pulses under the macro.

## Test plan
Use `STABLE_CYCLES` = 4 and `WIDTH` = 4 for simulation.
- **Reset:** assert `reset_n`=0 mid-simulation with `s_raw`=4'b1111 → all outputs 0 immediately. Release → `s_db`=4'b1111 at the 6th edge after release, with one `changed` pulse and `s_rise`=4'b1111 for 1 cycle.
- **Clean transition:** `s_raw[0]` goes 0→1 just before E0 and is held → `s_db` becomes 4'b0001 exactly at E0+5. `changed`=1 and `s_rise`=4'b0001 for exactly one cycle. `s_fall` stays 0.
- **Bounce:** toggle `s_raw[1]` 1, 0, 1 on three consecutive cycles, then hold 1 → no `s_db` change during the bounce. `s_db[1]`=1 exactly 4 cycles after `sync2[1]` last becomes 1, with a single `changed` pulse.
- **Short glitch:** `s_raw[2]` high for 3 cycles, then low → `s_db`, `changed` and `s_rise` never change.
- **Simultaneous commits:** `s_raw` goes 4'b0000→4'b1100 in one cycle → both bits commit on the same edge. `changed` is a single 1-cycle pulse and `s_rise`=4'b1100.
- **Macro undefined:** rerun the clean-transition test without `SWITCH_DEBOUNCER_EDGE_PULSE_EN` → identical `s_db`/`changed` timing. `s_rise` and `s_fall` stay 4'b0000 throughout.
